// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave front end: oversamples SCLK/CS_N/MOSI on clk, deserializes words, serializes tx_data.
// Optional macro SPI_SYNC_3FF_EN selects 3-flop pin synchronizers instead of 2.
module spi_slave_shifter #(
   parameter int unsigned WORD_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   input  logic [WORD_W-1:0] tx_data,
   output logic              miso,
   output logic              miso_oe,
   output logic              done,
   output logic [3:0]        cmd,
   output logic [WORD_W-1:0] rx_word,
   output logic              frame_err,
   output logic              busy
);

`ifdef SPI_SYNC_3FF_EN
   localparam int unsigned SyncStages = 3;
`else
   localparam int unsigned SyncStages = 2;
`endif

   localparam int unsigned CntW = $clog2(WORD_W + 1);
   localparam logic [CntW-1:0] CntFull = CntW'(WORD_W);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   logic [SyncStages-1:0] sclk_sync_q;
   logic [SyncStages-1:0] cs_sync_q;
   logic [SyncStages-1:0] mosi_sync_q;
   logic [SyncStages-1:0] sync_vld_q;
   logic                  sclk_prev_q;
   logic                  cs_prev_q;

   logic sclk_s, cs_s, mosi_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;

   state_e            state_q;
   logic [CntW-1:0]   bit_cnt_q;
   logic [WORD_W-1:0] rx_sh_q;
   logic [WORD_W-1:0] tx_sh_q;
   logic              word_seen_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sync_vld_q  <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SyncStages-2:0], sclk};
         cs_sync_q   <= {cs_sync_q[SyncStages-2:0], cs_n};
         mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], mosi};
         sync_vld_q  <= {sync_vld_q[SyncStages-2:0], 1'b1};
         sclk_prev_q <= sclk_s;
         // Hold the CS_N history low until the synchronizer carries a real pin sample, so a
         // CS_N that was already low through reset never looks like a falling edge.
         cs_prev_q   <= sync_vld_q[SyncStages-1] ? cs_s : 1'b0;
      end
   end

   assign sclk_s = sclk_sync_q[SyncStages-1];
   assign cs_s   = cs_sync_q[SyncStages-1];
   assign mosi_s = mosi_sync_q[SyncStages-1];

   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         rx_sh_q     <= '0;
         tx_sh_q     <= '0;
         word_seen_q <= 1'b0;
         miso_oe     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         frame_err   <= 1'b0;
         rx_word     <= '0;
         cmd         <= '0;
      end else begin
         done      <= 1'b0;
         frame_err <= 1'b0;
         case (state_q)
            StIdle: begin
               if (cs_fall) begin
                  state_q     <= StShift;
                  bit_cnt_q   <= '0;
                  tx_sh_q     <= tx_data;
                  word_seen_q <= 1'b0;
                  miso_oe     <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            StShift: begin
               if (cs_rise) begin
                  // CS_N wins over a coincident SCLK edge; that bit is dropped.
                  state_q   <= StIdle;
                  bit_cnt_q <= '0;
                  miso_oe   <= 1'b0;
                  busy      <= 1'b0;
                  if (bit_cnt_q == CntFull) begin
                     rx_word <= rx_sh_q;
                     cmd     <= rx_sh_q[WORD_W-1 -: 4];
                     done    <= 1'b1;
                  end else if (bit_cnt_q != '0) begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  if (bit_cnt_q == CntFull) begin
                     bit_cnt_q   <= '0;
                     rx_word     <= rx_sh_q;
                     cmd         <= rx_sh_q[WORD_W-1 -: 4];
                     done        <= 1'b1;
                     word_seen_q <= 1'b1;
                  end else if (sclk_rise) begin
                     rx_sh_q   <= {rx_sh_q[WORD_W-2:0], mosi_s};
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
                  if (sclk_fall) begin
                     if (bit_cnt_q == '0 && word_seen_q) begin
                        tx_sh_q <= tx_data;
                     end else begin
                        tx_sh_q <= {tx_sh_q[WORD_W-2:0], 1'b0};
                     end
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign miso = miso_oe & tx_sh_q[WORD_W-1];

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Scoreboard bench for spi_slave_shifter: stimulus pushes expected words, a monitor pops them on done.
module tb_spi_slave_shifter;

`ifdef SPI_SYNC_3FF_EN
   localparam int ExpLat = 5;
`else
   localparam int ExpLat = 4;
`endif

   logic        clk, rst, sclk, cs_n, mosi;
   logic [15:0] tx_data;
   logic        miso, miso_oe, done, frame_err, busy;
   logic [3:0]  cmd;
   logic [15:0] rx_word;

   spi_slave_shifter #(.WORD_W(16)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .tx_data(tx_data),
      .miso(miso), .miso_oe(miso_oe), .done(done), .cmd(cmd), .rx_word(rx_word),
      .frame_err(frame_err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_err = 0;
   int          n_done = 0;
   int          n_ferr = 0;
   int          last_rise_cyc = 0;
   logic        lat_check = 1'b0;
   logic        idle_watch = 1'b0;
   logic        idle_seen = 1'b0;
   logic [15:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every done pops one expected word
   always @(negedge clk) begin
      if (done) begin
         n_done++;
         if (exp_q.size() == 0) begin
            check("done_unexpected", 32'd1, 32'd0);
         end else begin
            logic [15:0] w;
            w = exp_q.pop_front();
            check("rx_word", {16'd0, rx_word}, {16'd0, w});
            check("cmd", {28'd0, cmd}, {28'd0, w[15:12]});
            if (lat_check) begin
               check("done_latency", cyc - last_rise_cyc, ExpLat);
               lat_check = 1'b0;
            end
         end
      end
      if (frame_err) n_ferr++;
      if (idle_watch && (busy || miso_oe || done)) idle_seen = 1'b1;
   end

   task automatic wcyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic frame_start();
      cs_n = 1'b0;
      wcyc(2);
   endtask

   task automatic frame_end();
      wcyc(4);
      cs_n = 1'b1;
      wcyc(8);
   endtask

   // Master side: drive nbits of w MSB first, sample MISO before each rising edge
   task automatic run_word(input logic [15:0] w, input logic [15:0] exp_miso, input int nbits,
                           input logic expect_done, input logic [15:0] next_tx);
      logic [15:0] got;
      got = '0;
      if (expect_done) exp_q.push_back(w);
      for (int i = 0; i < nbits; i++) begin
         mosi = w[15-i];
         wcyc(4);
         got[15-i] = miso;
         sclk = 1'b1;
         last_rise_cyc = cyc;
         wcyc(4);
         sclk = 1'b0;
         if (i == 15) tx_data = next_tx;
      end
      if (expect_done) check("miso_word", {16'd0, got}, {16'd0, exp_miso});
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_data = '0;
      wcyc(3);
      check("rst_miso", {31'd0, miso}, 0);
      check("rst_miso_oe", {31'd0, miso_oe}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_cmd", {28'd0, cmd}, 0);
      check("rst_rx_word", {16'd0, rx_word}, 0);
      check("rst_frame_err", {31'd0, frame_err}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      rst = 1'b0;
      wcyc(6);

      // Single word
      tx_data = 16'h1234;
      frame_start();
      lat_check = 1'b1;
      run_word(16'hA5C3, 16'h1234, 16, 1'b1, 16'h1234);
      frame_end();
      check("t1_no_frame_err", n_ferr, 0);
      check("t1_done_count", n_done, 1);

      // Two words in one frame, tx_data swapped after the first done
      tx_data = 16'h5555;
      frame_start();
      run_word(16'h3001, 16'h5555, 16, 1'b1, 16'hBEEF);
      run_word(16'h7FFF, 16'hBEEF, 16, 1'b1, 16'hBEEF);
      frame_end();
      check("t2_done_count", n_done, 3);

      // Aborted word, then a clean one
      frame_start();
      run_word(16'hFFFF, 16'h0, 7, 1'b0, 16'h0F0F);
      frame_end();
      check("t3_frame_err", n_ferr, 1);
      check("t3_miso_oe_drop", {31'd0, miso_oe}, 0);
      check("t3_busy_drop", {31'd0, busy}, 0);
      tx_data = 16'h0F0F;
      frame_start();
      run_word(16'h1111, 16'h0F0F, 16, 1'b1, 16'h0F0F);
      frame_end();

      // Reset mid-frame with CS_N held low through release
      frame_start();
      run_word(16'hABCD, 16'h0, 9, 1'b0, 16'h0);
      rst = 1'b1;
      #1;
      check("t4_rx_word_clr", {16'd0, rx_word}, 0);
      check("t4_cmd_clr", {28'd0, cmd}, 0);
      check("t4_miso_oe_clr", {31'd0, miso_oe}, 0);
      check("t4_busy_clr", {31'd0, busy}, 0);
      check("t4_miso_clr", {31'd0, miso}, 0);
      wcyc(3);
      rst = 1'b0;
      wcyc(4);
      run_word(16'hFFFF, 16'h0, 16, 1'b0, 16'h0);
      wcyc(4);
      check("t4_busy_after_rst", {31'd0, busy}, 0);
      check("t4_no_done", n_done, 4);
      cs_n = 1'b1;
      wcyc(8);
      tx_data = 16'hC0DE;
      frame_start();
      run_word(16'h5A69, 16'hC0DE, 16, 1'b1, 16'hC0DE);
      frame_end();

      // SCLK activity with CS_N high
      idle_watch = 1'b1;
      repeat (20) begin
         wcyc(4);
         sclk = 1'b1;
         wcyc(4);
         sclk = 1'b0;
      end
      wcyc(6);
      idle_watch = 1'b0;
      check("t5_idle_quiet", {31'd0, idle_seen}, 0);

      wcyc(10);
      check("queue_empty", exp_q.size(), 0);
      check("total_done", n_done, 5);
      check("total_frame_err", n_ferr, 1);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_slave_shifter.md
# spi_slave_shifter

- SPI mode-0 slave front end for the CycloneIII digitizer.
- Oversamples the external SCLK/CS_N/MOSI pins on the system clock, deserializes MOSI into words and serializes a supplied transmit word onto MISO.
- Issues a one-cycle `done` per completed word with the 4-bit command field extracted.
- Sits directly upstream of the SPI command state machine, feeding it `cmd` and `done`; takes `tx_data` from the register/FIFO mux that the state machine steers.

## Interface
Parameters:
- `WORD_W`, default 16: bits per SPI word. Legal range 8..32.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock. Must be at least 8x the SCLK frequency.
- `rst`  in  1  asynchronous, active-high reset.
- `sclk`  in  1  SPI clock pin, asynchronous to `clk`, idles low.
- `cs_n`  in  1  SPI chip select pin, active low, asynchronous.
- `mosi`  in  1  SPI data in, asynchronous.
- `tx_data`  in  WORD_W  word to transmit. Sampled at the load points defined under Operation.
- `miso`  out  1  SPI data out, MSB first.
- `miso_oe`  out  1  high while the frame is active. Pad tristate enable.
- `done`  out  1  one-cycle pulse when a full word has been received.
- `cmd`  out  4  `rx_word[WORD_W-1:WORD_W-4]`, updated with `done`.
- `rx_word`  out  WORD_W  last complete received word, updated with `done`.
- `frame_err`  out  1  one-cycle pulse when CS_N deasserts mid-word.
- `busy`  out  1  high in state SHIFT.

## Operation
- Input synchronizers: 2 flops each on `sclk`, `cs_n`, `mosi`.
  - Synchronizer reset values: `sclk` 0, `cs_n` 1, `mosi` 0.
  - Edge detect uses one further registered copy of each signal.
  - The `cs_n` previous-value register resets to 0. A CS_N already low at reset release is therefore not a falling edge.
- States: IDLE, SHIFT.
  - IDLE -> SHIFT on synced CS_N falling edge. Same cycle: `bit_cnt` <= 0, tx shift register <= `tx_data`, `miso_oe` <= 1.
  - SHIFT, SCLK rising edge: rx shift <= {rx shift[WORD_W-2:0], mosi_sync}, `bit_cnt`++.
  - SHIFT, `bit_cnt` reaches WORD_W: `bit_cnt` <= 0, `rx_word`/`cmd` updated, `done` pulses.
  - SHIFT, SCLK falling edge: if `bit_cnt` == 0 and at least one word has completed in this frame, tx shift <= `tx_data` (next-word load). Otherwise tx shift shifts left by 1.
  - `miso` = tx shift MSB at all times while `miso_oe` is 1; `miso` is 0 otherwise.
  - SHIFT -> IDLE on synced CS_N rising edge: `miso_oe` <= 0.
    - If `bit_cnt` != 0: `frame_err` pulses and no `done` is issued.
    - If `bit_cnt` == 0: clean end, no pulse.
- Multi-word frames (CS_N held low) are unlimited. Each word produces its own `done`.
- Width rules:
  - `bit_cnt` is $clog2(WORD_W+1) bits and never wraps past WORD_W.
  - `cmd` is always the top 4 bits of the word.

## Timing
- Reset values: `miso` 0, `miso_oe` 0, `done` 0, `cmd` 0, `rx_word` 0, `frame_err` 0, `busy` 0, state IDLE, `bit_cnt` 0.
- Pin-to-edge latency: 3 `clk` cycles (2 synchronizer flops plus 1 edge register).
- `done` asserts 1 cycle after the `clk` edge that registers the last SCLK rising edge, i.e. 4 cycles after the pin edge.
- `done` is high for exactly 1 cycle. `rx_word` and `cmd` are valid from the same cycle and hold until the next `done`.
- Next-word `tx_data` is sampled on the first SCLK falling edge after `done`. Downstream has at least half an SCLK period minus 4 cycles to present it.
- Simultaneous events:
  - CS_N rising edge with SCLK rising edge in the same detect cycle: CS_N wins and the bit is discarded.
  - SCLK edges while in IDLE are ignored.
- Reset mid-frame: all state clears immediately. A new frame requires CS_N to be seen high, then low.

## Configuration
- `SPI_SYNC_3FF_EN`
  - Defined: 3-flop synchronizers on all three pins. Pin-to-edge latency 4 cycles; `done` at 5 cycles after the pin edge. Minimum ratio `clk`/SCLK rises to 10.
  - Undefined: 2-flop synchronizers, as described above.

## Test plan
- Single word, `WORD_W`=16, MOSI 0xA5C3, `tx_data`=0x1234, SCLK = `clk`/8 -> one `done`, `cmd`=0xA, `rx_word`=0xA5C3, MISO bits 0x1234 MSB first, no `frame_err`.
- Two words, CS_N held low, MOSI 0x3001 then 0x7FFF, `tx_data` changed to 0xBEEF after the first `done` -> two `done` pulses with `cmd` 0x3 then 0x7, second word on MISO = 0xBEEF.
- CS_N raised after 7 SCLK rising edges -> `frame_err` pulses once, no `done`, `miso_oe` drops. A following full word with MOSI 0x1111 is received cleanly as 0x1111.
- `rst` asserted at bit 9 with CS_N low, then released with CS_N still low -> all outputs 0, no `done` until CS_N goes high then low. Next word is received correctly.
- 20 SCLK pulses with CS_N high -> `done`, `busy`, `miso_oe` stay 0.
- Single-word test repeated with `SPI_SYNC_3FF_EN` defined -> identical data, `done` exactly 1 cycle later than without the macro.
